// File: rtl/mem_write_arbiter_if.sv
// Requester and memory-side write streams of the write arbiter.
// master is the arbiter's view, slave the view of the surrounding system.
interface mem_write_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 512
);
  logic [N_REQ-1:0]              s_cmd_valid;
  logic [N_REQ-1:0]              s_cmd_ready;
  logic [N_REQ*64-1:0]           s_cmd_address;
  logic [N_REQ*32-1:0]           s_cmd_length;

  logic [N_REQ-1:0]              s_data_valid;
  logic [N_REQ-1:0]              s_data_ready;
  logic [N_REQ*DATA_WIDTH-1:0]   s_data_data;
  logic [N_REQ*DATA_WIDTH/8-1:0] s_data_keep;
  logic [N_REQ-1:0]              s_data_last;

  logic                          m_cmd_valid;
  logic                          m_cmd_ready;
  logic [63:0]                   m_cmd_address;
  logic [31:0]                   m_cmd_length;

  logic                          m_data_valid;
  logic                          m_data_ready;
  logic [DATA_WIDTH-1:0]         m_data_data;
  logic [DATA_WIDTH/8-1:0]       m_data_keep;
  logic                          m_data_last;

  modport master (
    input  s_cmd_valid, s_cmd_address, s_cmd_length,
    output s_cmd_ready,
    input  s_data_valid, s_data_data, s_data_keep, s_data_last,
    output s_data_ready,
    output m_cmd_valid, m_cmd_address, m_cmd_length,
    input  m_cmd_ready,
    output m_data_valid, m_data_data, m_data_keep, m_data_last,
    input  m_data_ready
  );

  modport slave (
    output s_cmd_valid, s_cmd_address, s_cmd_length,
    input  s_cmd_ready,
    output s_data_valid, s_data_data, s_data_keep, s_data_last,
    input  s_data_ready,
    input  m_cmd_valid, m_cmd_address, m_cmd_length,
    output m_cmd_ready,
    input  m_data_valid, m_data_data, m_data_keep, m_data_last,
    output m_data_ready
  );
endinterface

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter merging N requester write streams (cmd + data)
// onto one memory write port; zero-length commands are dropped.
module mem_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 512,
  parameter int GRANT_W    = 2
) (
  input  logic               clk,
  input  logic               rstn,
  mem_write_arbiter_if.master bus,
  output logic               busy,
  output logic [GRANT_W-1:0] grant_id,
  output logic [31:0]        cmd_count,
  output logic [31:0]        drop_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int SW = GRANT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [GRANT_W-1:0] rr_ptr;
  logic [GRANT_W-1:0] ptr_nxt;
  logic [GRANT_W-1:0] gid_nxt;
  logic [GRANT_W-1:0] sel;
  logic               hit;
  logic [63:0]        addr_q;
  logic [63:0]        addr_nxt;
  logic [31:0]        len_q;
  logic [31:0]        len_nxt;
  logic [31:0]        cc_nxt;
  logic [31:0]        dc_nxt;

  logic [63:0]         req_addr [N_REQ];
  logic [31:0]         req_len  [N_REQ];
  logic [DATA_WIDTH-1:0] req_data [N_REQ];
  logic [KW-1:0]       req_keep [N_REQ];

  logic [N_REQ-1:0]    cmd_rdy;
  logic [N_REQ-1:0]    data_rdy;
  logic                in_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_addr[i] = bus.s_cmd_address[i*64 +: 64];
    assign req_len[i]  = bus.s_cmd_length[i*32 +: 32];
    assign req_data[i] = bus.s_data_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign req_keep[i] = bus.s_data_keep[i*KW +: KW];
  end

  function automatic logic [GRANT_W-1:0] inc_mod(
    input logic [GRANT_W-1:0] v
  );
    if (v == GRANT_W'(N_REQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    logic [GRANT_W:0] sum;
    sel = '0;
    hit = 1'b0;
    sum = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + SW'(i);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      if (bus.s_cmd_valid[sum[GRANT_W-1:0]]) begin
        sel = sum[GRANT_W-1:0];
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    gid_nxt   = grant_id;
    addr_nxt  = addr_q;
    len_nxt   = len_q;
    cc_nxt    = cmd_count;
    dc_nxt    = drop_count;
    unique case (state)
      IDLE: begin
        if (hit) begin
          gid_nxt  = sel;
          addr_nxt = req_addr[sel];
          len_nxt  = req_len[sel];
          if (req_len[sel] == '0) begin
            dc_nxt  = drop_count + 32'd1;
            ptr_nxt = inc_mod(sel);
          end else begin
            state_nxt = CMD;
          end
        end
      end
      CMD: begin
        if (bus.m_cmd_ready) begin
          state_nxt = DATA;
          cc_nxt    = cmd_count + 32'd1;
        end
      end
      DATA: begin
        if (bus.s_data_valid[grant_id] && bus.m_data_ready
            && bus.s_data_last[grant_id]) begin
          state_nxt = IDLE;
          ptr_nxt   = inc_mod(grant_id);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cmd_count  <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= ptr_nxt;
      grant_id   <= gid_nxt;
      addr_q     <= addr_nxt;
      len_q      <= len_nxt;
      cmd_count  <= cc_nxt;
      drop_count <= dc_nxt;
    end
  end

  // The cmd ready is combinational from requester valids, so gate it
  // with reset to keep every handshake output low while held in reset.
  always_comb begin
    cmd_rdy  = '0;
    data_rdy = '0;
    in_data  = (state == DATA);
    if (state == IDLE && hit && rstn) cmd_rdy[sel] = 1'b1;
    if (in_data) data_rdy[grant_id] = bus.m_data_ready;
  end

  assign bus.s_cmd_ready   = cmd_rdy;
  assign bus.s_data_ready  = data_rdy;
  assign bus.m_cmd_valid   = (state == CMD);
  assign bus.m_cmd_address = addr_q;
  assign bus.m_cmd_length  = len_q;
  assign bus.m_data_valid  = in_data & bus.s_data_valid[grant_id];
  assign bus.m_data_last   = in_data & bus.s_data_last[grant_id];
  assign bus.m_data_data   = in_data ? req_data[grant_id] : '0;
  assign bus.m_data_keep   = in_data ? req_keep[grant_id] : '0;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Random requester traffic against a transaction-level arbiter model.
// Includes a mid-transfer reset and a final drain check.
module tb_mem_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int GW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          busy;
  logic [GW-1:0] grant_id;
  logic [31:0]   cmd_count;
  logic [31:0]   drop_count;

  always #5 clk = ~clk;

  mem_write_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  mem_write_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .GRANT_W(GW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .busy(busy),
    .grant_id(grant_id),
    .cmd_count(cmd_count),
    .drop_count(drop_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [599:0] got,
                     input logic [599:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // requester driver state
  int            ph [N];
  int            wt [N];
  int            nb [N];
  int            left [N];
  logic          cv [N];
  logic          dv [N];
  logic [63:0]   c_addr [N];
  logic [31:0]   c_len [N];
  logic [DW-1:0] d_cur [N];
  logic [KW-1:0] k_cur [N];
  logic          l_cur [N];
  logic          hs_c [N];
  logic          hs_d [N];
  beat_t         exq [N][$];
  logic          m_cr;
  logic          m_dr;
  bit            stop;

  // model state: 0 free, 1 command pending, 2 data
  int            mph;
  int            mg;
  int            mptr;
  logic [31:0]   mcc;
  logic [31:0]   mdc;
  logic [GW-1:0] mgid;
  logic [63:0]   ea;
  logic [31:0]   el;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int j = 0; j < DW / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic new_cmd(input int i);
    c_addr[i] = {$urandom, $urandom};
    c_len[i]  = ($urandom_range(0, 5) == 0) ? 32'd0
                : 32'($urandom_range(1, 4096));
    nb[i] = $urandom_range(1, 4);
    cv[i] = 1'b1;
    ph[i] = 1;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.s_cmd_valid[i]             = cv[i];
      bus.s_cmd_address[i*64 +: 64]  = c_addr[i];
      bus.s_cmd_length[i*32 +: 32]   = c_len[i];
      bus.s_data_valid[i]            = dv[i];
      bus.s_data_data[i*DW +: DW]    = d_cur[i];
      bus.s_data_keep[i*KW +: KW]    = k_cur[i];
      bus.s_data_last[i]             = l_cur[i];
    end
    bus.m_cmd_ready  = m_cr;
    bus.m_data_ready = m_dr;
  endtask

  task automatic drive(input int cyc);
    for (int i = 0; i < N; i++) begin
      if (ph[i] == 1 && hs_c[i]) begin
        cv[i] = 1'b0;
        if (c_len[i] == 0) begin
          ph[i] = 0;
          wt[i] = $urandom_range(0, 4);
        end else begin
          ph[i] = 2;
          left[i] = nb[i];
          dv[i] = 1'b0;
        end
      end else if (ph[i] == 2 && hs_d[i]) begin
        dv[i] = 1'b0;
        left[i]--;
        if (left[i] == 0) begin
          ph[i] = 0;
          wt[i] = $urandom_range(0, 4);
        end
      end
      if (ph[i] == 0 && !stop) begin
        if (wt[i] > 0) wt[i]--;
        else new_cmd(i);
      end
      if (ph[i] == 2 && !dv[i] && $urandom_range(0, 3) != 0) begin
        d_cur[i] = rnd_data();
        k_cur[i] = {$urandom, $urandom};
        l_cur[i] = (left[i] == 1);
        exq[i].push_back('{d: d_cur[i], k: k_cur[i], l: l_cur[i]});
        dv[i] = 1'b1;
      end
    end
    m_cr = ($urandom_range(0, 3) != 0) && (cyc % 50 >= 6);
    m_dr = ($urandom_range(0, 2) != 0);
  endtask

  task automatic model_step();
    logic [N-1:0] er;
    logic [N-1:0] edr;
    logic [31:0]  l;
    beat_t        b;
    int           g;
    er  = '0;
    edr = '0;
    g   = -1;
    chk("cmd_count", cmd_count, mcc);
    chk("drop_count", drop_count, mdc);
    chk("grant_id", grant_id, mgid);
    chk("busy", busy, mph != 0);
    if (mph == 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (g < 0 && bus.s_cmd_valid[j]) g = j;
      end
      if (g >= 0) er[g] = 1'b1;
    end
    if (mph == 2) edr[mg] = bus.m_data_ready;
    chk("s_cmd_ready", bus.s_cmd_ready, er);
    chk("m_cmd_valid", bus.m_cmd_valid, mph == 1);
    if (mph == 1)
      chk("m_cmd", {bus.m_cmd_address, bus.m_cmd_length}, {ea, el});
    chk("s_data_ready", bus.s_data_ready, edr);
    chk("m_data_valid", bus.m_data_valid,
        mph == 2 && bus.s_data_valid[mg]);
    for (int i = 0; i < N; i++) begin
      hs_c[i] = bus.s_cmd_valid[i] & bus.s_cmd_ready[i];
      hs_d[i] = bus.s_data_valid[i] & bus.s_data_ready[i];
    end
    if (mph == 0 && g >= 0) begin
      mgid = GW'(g);
      l = bus.s_cmd_length[g*32 +: 32];
      if (l == 0) begin
        mdc++;
        mptr = (g + 1) % N;
      end else begin
        mph = 1;
        mg  = g;
        ea  = bus.s_cmd_address[g*64 +: 64];
        el  = l;
      end
    end else if (mph == 1 && bus.m_cmd_ready) begin
      mcc++;
      mph = 2;
    end else if (mph == 2 && bus.s_data_valid[mg] && bus.m_data_ready) begin
      chk("beat_avail", exq[mg].size() != 0, 1'b1);
      if (exq[mg].size() != 0) begin
        b = exq[mg].pop_front();
        chk("beat", {bus.m_data_data, bus.m_data_keep, bus.m_data_last}, b);
        if (b.l) begin
          mph  = 0;
          mptr = (mg + 1) % N;
        end
      end
    end
  endtask

  task automatic model_reset();
    mph = 0; mg = 0; mptr = 0;
    mcc = '0; mdc = '0; mgid = '0;
    ea = '0; el = '0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {busy, grant_id, cmd_count, drop_count,
              bus.m_cmd_valid, bus.m_cmd_address, bus.m_cmd_length,
              bus.m_data_valid, bus.m_data_last,
              bus.s_cmd_ready, bus.s_data_ready}, '0);
  endtask

  task automatic clear_drivers();
    for (int i = 0; i < N; i++) begin
      ph[i] = 0; wt[i] = $urandom_range(2, 6);
      nb[i] = 1; left[i] = 0;
      cv[i] = 1'b0; dv[i] = 1'b0;
      c_addr[i] = '0; c_len[i] = '0;
      d_cur[i] = '0; k_cur[i] = '0; l_cur[i] = 1'b0;
      hs_c[i] = 1'b0; hs_d[i] = 1'b0;
      exq[i].delete();
    end
  endtask

  // Reset mid-transfer: requester valids stay high so the gating of
  // the combinational ready is exercised; requester 3 waits alone.
  task automatic do_reset();
    #1 rstn = 1'b0;
    #1 chk_reset_outs("rst_mid_outs");
    clear_drivers();
    new_cmd(3);
    c_len[3] = 32'd64;
    nb[3] = 2;
    apply();
    model_reset();
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  function automatic bit all_idle();
    bit r;
    r = (mph == 0);
    for (int i = 0; i < N; i++) if (ph[i] != 0) r = 0;
    return r;
  endfunction

  initial begin
    bit rst_done;
    int q_left;
    rst_done = 0;
    stop = 0;
    m_cr = 1'b0;
    m_dr = 1'b0;
    clear_drivers();
    for (int i = 0; i < N; i++) cv[i] = 1'b1;
    c_len[1] = 32'd8;
    apply();
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("rst_init_outs");
    for (int i = 0; i < N; i++) cv[i] = 1'b0;
    apply();
    model_reset();
    #1 rstn = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      model_step();
      if (!rst_done && cyc > 1500 && mph == 2) begin
        rst_done = 1;
        do_reset();
        continue;
      end
      @(posedge clk);
      #1;
      drive(cyc);
      apply();
    end
    chk("reset_exercised", rst_done, 1'b1);

    stop = 1;
    for (int c = 0; c < 2000 && !all_idle(); c++) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      drive(c + 6);
      apply();
    end
    chk("drained", all_idle(), 1'b1);
    q_left = 0;
    for (int i = 0; i < N; i++) q_left += exq[i].size();
    chk("beats_left", q_left, 0);
    chk("cmds_seen", cmd_count != 0, 1'b1);
    chk("drops_seen", drop_count != 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
